// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: arbitrates hazard sources into PC-stall and
// stage-flush controls, sequences the debug halt handshake and counts stall cycles.
module pipe_hold_ctrl #(
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_ex_i,
  input  logic        hold_flag_rib_i,
  input  logic        hold_flag_clint_i,
  input  logic        dm_halt_req_i,
  input  logic        stall_cnt_clr_i,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic        hold_pc_o,
  output logic        flush_if_id_o,
  output logic        flush_id_ex_o,
  output logic        dm_halted_o,
  output logic [31:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED,
    ST_RESUME
  } state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t      state_q, state_d;
  logic [3:0]  drain_q, drain_d;
  logic        halted_q;
  logic [31:0] stall_q;
  logic        core_hold;

  // EX busy and trap entry both keep in-flight instructions from retiring
  assign core_hold = hold_flag_ex_i | hold_flag_clint_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_RUN;
      drain_q  <= 4'd0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      halted_q <= (state_d == ST_HALTED);
    end
  end

  always_comb begin
    state_d       = state_q;
    drain_d       = drain_q;
    jump_flag_o   = 1'b0;
    hold_pc_o     = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (jump_flag_i) begin
          jump_flag_o   = 1'b1;
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
        end else if (core_hold) begin
          hold_pc_o     = 1'b1;
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
        end else if (hold_flag_rib_i) begin
          hold_pc_o     = 1'b1;
          flush_if_id_o = 1'b1;
        end
        if (dm_halt_req_i) begin
          state_d = ST_DRAIN;
          drain_d = DRAIN_LOAD;
        end
      end

      ST_DRAIN: begin
        // A late jump still loads the PC so the halt PC points at the target
        hold_pc_o     = 1'b1;
        flush_if_id_o = 1'b1;
        if (jump_flag_i) begin
          jump_flag_o   = 1'b1;
          flush_id_ex_o = 1'b1;
        end
        if (core_hold) begin
          flush_id_ex_o = 1'b1;
        end
        if (!dm_halt_req_i) begin
          state_d = ST_RUN;
          drain_d = 4'd0;
        end else if (!core_hold) begin
          if (drain_q <= 4'd1) begin
            state_d = ST_HALTED;
            drain_d = 4'd0;
          end else begin
            drain_d = drain_q - 4'd1;
          end
        end
      end

      ST_HALTED: begin
        hold_pc_o     = 1'b1;
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        if (!dm_halt_req_i) begin
          state_d = ST_RESUME;
        end
      end

      ST_RESUME: begin
        // Fetch restarts; the word fetched at the held PC is stale
        flush_if_id_o = 1'b1;
        state_d       = ST_RUN;
      end

      default: begin
        state_d = ST_RUN;
        drain_d = 4'd0;
      end
    endcase

    if (!rst) begin
      jump_flag_o   = 1'b0;
      hold_pc_o     = 1'b0;
      flush_if_id_o = 1'b0;
      flush_id_ex_o = 1'b0;
    end
  end

  assign jump_addr_o = jump_flag_o ? jump_addr_i : 32'h0;

  // Saturating stall counter; clear wins over increment
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= 32'h0;
    end else if (stall_cnt_clr_i) begin
      stall_q <= 32'h0;
    end else if (hold_pc_o && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign dm_halted_o = halted_q;
  assign stall_cnt_o = stall_q;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Self-checking bench for pipe_hold_ctrl: table vectors, hand-written halt and
// counter sequences, and randomized traffic against a behavioural model.
module tb_pipe_hold_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = 32'h0;
  logic        hold_flag_ex_i = 1'b0;
  logic        hold_flag_rib_i = 1'b0;
  logic        hold_flag_clint_i = 1'b0;
  logic        dm_halt_req_i = 1'b0;
  logic        stall_cnt_clr_i = 1'b0;
  logic        jump_flag_o;
  logic [31:0] jump_addr_o;
  logic        hold_pc_o;
  logic        flush_if_id_o;
  logic        flush_id_ex_o;
  logic        dm_halted_o;
  logic [31:0] stall_cnt_o;

  int total = 0;
  int bad = 0;

  pipe_hold_ctrl #(.DRAIN_CYCLES(2)) dut (
    .clk(clk), .rst(rst),
    .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .hold_flag_ex_i(hold_flag_ex_i), .hold_flag_rib_i(hold_flag_rib_i),
    .hold_flag_clint_i(hold_flag_clint_i), .dm_halt_req_i(dm_halt_req_i),
    .stall_cnt_clr_i(stall_cnt_clr_i),
    .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o), .hold_pc_o(hold_pc_o),
    .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
    .dm_halted_o(dm_halted_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        jump;
    logic [31:0] addr;
    logic        ex;
    logic        rib;
    logic        clint;
    logic        req;
    logic        clr;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic        jf;
    logic [31:0] ja;
    logic        hp;
    logic        fi;
    logic        fe;
  } vec_t;

  // Behavioural model: debug mode name, remaining drain work, stall total
  typedef enum {M_RUN, M_DRAIN, M_HALTED, M_RESUME} mode_t;
  mode_t   mMode = M_RUN;
  int      mDrainLeft = 0;
  longint  mStall = 0;
  logic    mHalted = 1'b0;
  logic        eJf, eHp, eFi, eFe;
  logic [31:0] eJa;

  function automatic stim_t mk(logic jump, logic [31:0] addr, logic ex, logic rib,
                               logic clint, logic req, logic clr);
    stim_t s;
    s.jump = jump; s.addr = addr; s.ex = ex; s.rib = rib;
    s.clint = clint; s.req = req; s.clr = clr;
    return s;
  endfunction

  task automatic modelComb();
    logic busy;
    busy = hold_flag_ex_i | hold_flag_clint_i;
    eJf = 0; eHp = 0; eFi = 0; eFe = 0;
    if (rst) begin
      case (mMode)
        M_RUN: begin
          if (jump_flag_i) begin eJf = 1; eFi = 1; eFe = 1; end
          else if (busy) begin eHp = 1; eFi = 1; eFe = 1; end
          else if (hold_flag_rib_i) begin eHp = 1; eFi = 1; end
        end
        M_DRAIN: begin
          eHp = 1; eFi = 1;
          eJf = jump_flag_i;
          eFe = jump_flag_i | busy;
        end
        M_HALTED: begin eHp = 1; eFi = 1; eFe = 1; end
        M_RESUME: eFi = 1;
        default: ;
      endcase
    end
    eJa = eJf ? jump_addr_i : 32'h0;
  endtask

  task automatic modelEdge();
    modelComb();
    if (stall_cnt_clr_i) mStall = 0;
    else if (eHp) mStall = (mStall >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : mStall + 1;
    case (mMode)
      M_RUN: if (dm_halt_req_i) begin mMode = M_DRAIN; mDrainLeft = 2; end
      M_DRAIN: begin
        if (!dm_halt_req_i) begin mMode = M_RUN; mDrainLeft = 0; end
        else if (!(hold_flag_ex_i | hold_flag_clint_i)) begin
          mDrainLeft = mDrainLeft - 1;
          if (mDrainLeft == 0) mMode = M_HALTED;
        end
      end
      M_HALTED: if (!dm_halt_req_i) mMode = M_RESUME;
      M_RESUME: mMode = M_RUN;
      default: ;
    endcase
    mHalted = (mMode == M_HALTED);
  endtask

  task automatic modelReset();
    mMode = M_RUN; mDrainLeft = 0; mStall = 0; mHalted = 0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAgainstModel();
    modelComb();
    checkOutput("jump_flag_o", 32'(jump_flag_o), 32'(eJf));
    checkOutput("jump_addr_o", jump_addr_o, eJa);
    checkOutput("hold_pc_o", 32'(hold_pc_o), 32'(eHp));
    checkOutput("flush_if_id_o", 32'(flush_if_id_o), 32'(eFi));
    checkOutput("flush_id_ex_o", 32'(flush_id_ex_o), 32'(eFe));
    checkOutput("dm_halted_o", 32'(dm_halted_o), 32'(mHalted));
    checkOutput("stall_cnt_o", stall_cnt_o, mStall[31:0]);
  endtask

  // Drive one cycle of inputs shortly after an edge, check, then take the edge
  task automatic applyStimulus(input stim_t s);
    jump_flag_i = s.jump; jump_addr_i = s.addr; hold_flag_ex_i = s.ex;
    hold_flag_rib_i = s.rib; hold_flag_clint_i = s.clint;
    dm_halt_req_i = s.req; stall_cnt_clr_i = s.clr;
    #2;
    checkAgainstModel();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  stim_t idle;
  vec_t  vecs[$];

  initial begin
    idle = mk(0, 32'h0, 0, 0, 0, 0, 0);

    // Reset with all inputs quiet, then with hazards active
    #2;
    checkAgainstModel();
    jump_flag_i = 1; jump_addr_i = 32'hDEAD_BEEF; hold_flag_ex_i = 1; hold_flag_rib_i = 1;
    #1;
    checkOutput("reset_jump_gated", 32'(jump_flag_o), 32'h0);
    checkOutput("reset_addr_gated", jump_addr_o, 32'h0);
    checkOutput("reset_hold_gated", 32'(hold_pc_o), 32'h0);
    jump_flag_i = 0; jump_addr_i = 0; hold_flag_ex_i = 0; hold_flag_rib_i = 0;
    @(posedge clk); #2;
    rst = 1;
    @(posedge clk); #1;
    applyStimulus(idle);
    checkOutput("run_after_reset_hold", 32'(hold_pc_o), 32'h0);

    // RUN-state priority table
    vecs.push_back('{mk(1, 32'h0000_0100, 1, 0, 0, 0, 0), 1, 32'h100, 0, 1, 1});
    vecs.push_back('{mk(0, 32'h0000_0100, 1, 0, 0, 0, 0), 0, 32'h0,   1, 1, 1});
    vecs.push_back('{mk(0, 32'h0000_0000, 0, 0, 1, 0, 0), 0, 32'h0,   1, 1, 1});
    vecs.push_back('{mk(0, 32'h0000_0000, 0, 1, 0, 0, 0), 0, 32'h0,   1, 1, 0});
    vecs.push_back('{mk(0, 32'h0000_0000, 1, 1, 0, 0, 0), 0, 32'h0,   1, 1, 1});
    vecs.push_back('{mk(1, 32'h8000_0004, 0, 1, 1, 0, 0), 1, 32'h8000_0004, 0, 1, 1});
    vecs.push_back('{mk(0, 32'h1234_5678, 0, 0, 0, 0, 0), 0, 32'h0,   0, 0, 0});
    foreach (vecs[i]) begin
      jump_flag_i = vecs[i].s.jump; jump_addr_i = vecs[i].s.addr;
      hold_flag_ex_i = vecs[i].s.ex; hold_flag_rib_i = vecs[i].s.rib;
      hold_flag_clint_i = vecs[i].s.clint; dm_halt_req_i = 0; stall_cnt_clr_i = 0;
      #1;
      checkOutput($sformatf("vec%0d_jf", i), 32'(jump_flag_o), 32'(vecs[i].jf));
      checkOutput($sformatf("vec%0d_ja", i), jump_addr_o, vecs[i].ja);
      checkOutput($sformatf("vec%0d_hp", i), 32'(hold_pc_o), 32'(vecs[i].hp));
      checkOutput($sformatf("vec%0d_fi", i), 32'(flush_if_id_o), 32'(vecs[i].fi));
      checkOutput($sformatf("vec%0d_fe", i), 32'(flush_id_ex_o), 32'(vecs[i].fe));
      applyStimulus(vecs[i].s);
    end

    // Five bus-hold cycles count five stalls
    applyStimulus(mk(0, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 5; i++) applyStimulus(mk(0, 0, 0, 1, 0, 0, 0));
    checkOutput("stall_after_rib5", stall_cnt_o, 32'd5);

    // Halt with one frozen drain cycle: halted after the 4th edge
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 0));
    applyStimulus(mk(0, 0, 1, 0, 0, 1, 0));
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 0));
    checkOutput("halted_early", 32'(dm_halted_o), 32'h0);
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 0));
    checkOutput("halted_after_4", 32'(dm_halted_o), 32'h1);
    applyStimulus(mk(0, 0, 1, 1, 1, 1, 0));
    applyStimulus(idle);
    checkOutput("resume_halted", 32'(dm_halted_o), 32'h0);
    #1;
    checkOutput("resume_hold", 32'(hold_pc_o), 32'h0);
    checkOutput("resume_flush_if", 32'(flush_if_id_o), 32'h1);
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 0));
    #1;
    checkOutput("run_after_resume", 32'(flush_if_id_o), 32'h0);
    applyStimulus(idle);
    applyStimulus(idle);

    // One-cycle halt pulse aborts the drain
    applyStimulus(mk(0, 0, 0, 0, 0, 1, 0));
    #1;
    checkOutput("pulse_drain_hold", 32'(hold_pc_o), 32'h1);
    applyStimulus(idle);
    #1;
    checkOutput("pulse_back_run", 32'(hold_pc_o), 32'h0);
    checkOutput("pulse_never_halted", 32'(dm_halted_o), 32'h0);
    applyStimulus(idle);

    // Counter saturation and clear priority
    dut.stall_q = 32'hFFFF_FFFE;
    mStall = 64'hFFFF_FFFE;
    for (int i = 0; i < 3; i++) applyStimulus(mk(0, 0, 0, 1, 0, 0, 0));
    checkOutput("stall_saturated", stall_cnt_o, 32'hFFFF_FFFF);
    applyStimulus(mk(0, 0, 1, 0, 0, 0, 1));
    checkOutput("stall_clr_wins", stall_cnt_o, 32'h0);

    // Reset while halted returns straight to RUN values
    for (int i = 0; i < 4; i++) applyStimulus(mk(0, 0, 0, 0, 0, 1, 0));
    checkOutput("halted_before_reset", 32'(dm_halted_o), 32'h1);
    dm_halt_req_i = 1;
    rst = 0;
    #1;
    modelReset();
    checkOutput("reset_mid_halted", 32'(dm_halted_o), 32'h0);
    checkOutput("reset_mid_hold", 32'(hold_pc_o), 32'h0);
    checkOutput("reset_mid_stall", stall_cnt_o, 32'h0);
    dm_halt_req_i = 0;
    @(posedge clk); #2;
    rst = 1;
    @(posedge clk); #1;
    applyStimulus(idle);

    // Randomized traffic against the model
    begin
      logic req = 0;
      for (int n = 0; n < 3000; n++) begin
        stim_t s;
        if ($urandom_range(0, 15) == 0) req = ~req;
        s.req   = req;
        s.jump  = ($urandom_range(0, 5) == 0) && (mMode != M_HALTED);
        s.addr  = $urandom;
        s.ex    = ($urandom_range(0, 4) == 0);
        s.rib   = ($urandom_range(0, 3) == 0);
        s.clint = ($urandom_range(0, 9) == 0);
        s.clr   = ($urandom_range(0, 63) == 0);
        applyStimulus(s);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
